// File: rtl/rf_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package rf_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;
    localparam int RF_NREGS  = 2 ** RF_ADDR_W;
    localparam int RF_MAX_RD = 4;

    typedef logic [RF_ADDR_W-1:0] rf_idx_t;
    typedef logic [RF_DATA_W-1:0] rf_word_t;

endpackage

// File: rtl/rf_read_port.sv
// One read port: zero-register handling, write-to-read bypass and RAW busy flag.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    localparam int NREGS   = 2 ** ADDR_W
) (
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [NREGS*DATA_W-1:0] mem_flat,
    input  logic [NREGS-1:0]        pend_vec,
    input  logic                    wr0_en,
    input  logic [ADDR_W-1:0]       wr0_addr,
    input  logic [DATA_W-1:0]       wr0_data,
    input  logic                    wr1_en,
    input  logic [ADDR_W-1:0]       wr1_addr,
    input  logic [DATA_W-1:0]       wr1_data,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_busy
);

    logic hit0;
    logic hit1;
    logic is_zero;

    assign hit0    = wr0_en && (wr0_addr == rd_addr);
    assign hit1    = wr1_en && (wr1_addr == rd_addr);
    assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

    // wr0 carries the younger result, so it beats wr1 on a shared index
    always_comb begin
        rd_data = mem_flat[rd_addr*DATA_W +: DATA_W];
        if (reset || is_zero) begin
            rd_data = '0;
        end else if (hit0) begin
            rd_data = wr0_data;
        end else if (hit1) begin
            rd_data = wr1_data;
        end
    end

    assign rd_busy = !reset && !is_zero && pend_vec[rd_addr] && !hit0 && !hit1;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with two write ports, read bypass and per-register pending bits.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int NREGS   = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [NREGS-1:0]         busy_vec
);

    logic [DATA_W-1:0]       mem_q [NREGS];
    logic [DATA_W-1:0]       mem_d [NREGS];
    logic [NREGS-1:0]        pend_q;
    logic [NREGS-1:0]        pend_d;
    logic [NREGS*DATA_W-1:0] mem_flat;
    logic                    wr0_ok;
    logic                    wr1_ok;

    assign wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

    // wr0 applied last so it wins a same-index collision
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            mem_d[r] = mem_q[r];
        end
        if (wr1_ok) begin
            mem_d[wr1_addr] = wr1_data;
        end
        if (wr0_ok) begin
            mem_d[wr0_addr] = wr0_data;
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < NREGS; r++) begin
            if (flush) begin
                pend_d[r] = 1'b0;
            end else if (iss_en && (iss_addr == ADDR_W'(r))) begin
                pend_d[r] = 1'b1;
            end else if ((wr0_en && (wr0_addr == ADDR_W'(r))) ||
                         (wr1_en && (wr1_addr == ADDR_W'(r)))) begin
                pend_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
            pend_q <= pend_d;
        end
    end

    assign busy_vec = pend_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign mem_flat[g*DATA_W +: DATA_W] = mem_q[g];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .reset    (reset),
            .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
            .mem_flat (mem_flat),
            .pend_vec (pend_q),
            .wr0_en   (wr0_en),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data),
            .rd_data  (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed checks on the default file (ZERO_REG 1 and 0) plus a model-checked 4-read, 16-entry variant.
module tb_regfile_scoreboard;

    logic       clk = 1'b0;
    logic       reset;

    logic [5:0]  rd_addr;
    logic [15:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [7:0]  busy_vec_a, busy_vec_b;
    logic        wr0_en, wr1_en, iss_en, flush;
    logic [2:0]  wr0_addr, wr1_addr, iss_addr;
    logic [7:0]  wr0_data, wr1_data;

    logic [15:0] c_rd_addr;
    logic [31:0] c_rd_data;
    logic [3:0]  c_rd_busy;
    logic [15:0] c_busy_vec;
    logic        c_wr0_en, c_wr1_en, c_iss_en, c_flush;
    logic [3:0]  c_wr0_addr, c_wr1_addr, c_iss_addr;
    logic [7:0]  c_wr0_data, c_wr1_data;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mmem [16];
    logic [15:0] mpend;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_a));

    regfile_scoreboard #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec_b));

    regfile_scoreboard #(.DATA_W(8), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dut_c (
        .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr0_en(c_wr0_en), .wr0_addr(c_wr0_addr), .wr0_data(c_wr0_data),
        .wr1_en(c_wr1_en), .wr1_addr(c_wr1_addr), .wr1_data(c_wr1_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr), .flush(c_flush), .busy_vec(c_busy_vec));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        wr0_en = 0; wr1_en = 0; iss_en = 0; flush = 0;
    endtask

    function automatic logic [7:0] m_data(input logic [3:0] a);
        if (a == 4'd0) return 8'h00;
        if (c_wr0_en && c_wr0_addr == a) return c_wr0_data;
        if (c_wr1_en && c_wr1_addr == a) return c_wr1_data;
        return mmem[a];
    endfunction

    function automatic logic m_busy(input logic [3:0] a);
        if (a == 4'd0) return 1'b0;
        return mpend[a] && !(c_wr0_en && c_wr0_addr == a) && !(c_wr1_en && c_wr1_addr == a);
    endfunction

    initial begin
        reset = 1;
        rd_addr = '0; wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
        wr0_data = '0; wr1_data = '0;
        idle_a();
        c_rd_addr = '0; c_wr0_en = 0; c_wr1_en = 0; c_iss_en = 0; c_flush = 0;
        c_wr0_addr = '0; c_wr1_addr = '0; c_iss_addr = '0; c_wr0_data = '0; c_wr1_data = '0;
        for (int r = 0; r < 16; r++) mmem[r] = 8'h00;
        mpend = '0;

        repeat (2) tick();
        chk("reset_rd_data", {16'h0, rd_data_a}, 32'h0);
        chk("reset_busy_vec", {24'h0, busy_vec_a}, 32'h0);
        reset = 0;
        tick();

        // write bypass then array read of R3
        rd_addr = {3'd0, 3'd3};
        wr1_en = 1; wr1_addr = 3'd3; wr1_data = 8'h5A;
        #1 chk("bypass_wr1_r3", {24'h0, rd_data_a[7:0]}, 32'h5A);
        tick(); idle_a();
        #1 chk("array_r3", {24'h0, rd_data_a[7:0]}, 32'h5A);

        // simultaneous writes to R2
        rd_addr = {3'd2, 3'd3};
        wr0_en = 1; wr0_addr = 3'd2; wr0_data = 8'h11;
        wr1_en = 1; wr1_addr = 3'd2; wr1_data = 8'h22;
        #1 chk("bypass_wr0_wins", {24'h0, rd_data_a[15:8]}, 32'h11);
        tick(); idle_a();
        #1 chk("array_wr0_wins", {24'h0, rd_data_a[15:8]}, 32'h11);

        // R0 write, hardwired zero vs ordinary
        wr0_en = 1; wr0_addr = 3'd0; wr0_data = 8'hFF;
        iss_en = 1; iss_addr = 3'd0;
        tick(); idle_a();
        rd_addr = {3'd2, 3'd0};
        #1 chk("r0_zero_reg1", {24'h0, rd_data_a[7:0]}, 32'h00);
        chk("r0_busy_zero_reg1", {30'h0, rd_busy_a}, 32'h0);
        chk("r0_busyvec_zero_reg1", {24'h0, busy_vec_a}, 32'h0);
        chk("r0_zero_reg0", {24'h0, rd_data_b[7:0]}, 32'hFF);
        chk("r0_busyvec_zero_reg0", {24'h0, busy_vec_b}, 32'h01);

        // scoreboard on R5
        iss_en = 1; iss_addr = 3'd5;
        tick(); idle_a();
        rd_addr = {3'd2, 3'd5};
        #1 chk("iss_r5_busy_vec", {24'h0, busy_vec_a}, 32'h20);
        chk("iss_r5_rd_busy", {30'h0, rd_busy_a}, 32'h1);
        wr1_en = 1; wr1_addr = 3'd5; wr1_data = 8'h33;
        #1 chk("wb_r5_rd_busy", {30'h0, rd_busy_a}, 32'h0);
        chk("wb_r5_data", {24'h0, rd_data_a[7:0]}, 32'h33);
        chk("wb_r5_bit_still_set", {24'h0, busy_vec_a}, 32'h20);
        tick(); idle_a();
        #1 chk("wb_r5_cleared", {24'h0, busy_vec_a}, 32'h00);
        iss_en = 1; iss_addr = 3'd5;
        wr1_en = 1; wr1_addr = 3'd5; wr1_data = 8'h44;
        tick(); idle_a();
        #1 chk("iss_beats_wr_vec", {24'h0, busy_vec_a}, 32'h20);
        chk("iss_beats_wr_data", {24'h0, rd_data_a[7:0]}, 32'h44);
        chk("iss_beats_wr_busy", {30'h0, rd_busy_a}, 32'h1);

        // flush with same-cycle issue and write
        iss_en = 1; iss_addr = 3'd6;
        tick(); idle_a();
        #1 chk("iss_r6_vec", {24'h0, busy_vec_a}, 32'h60);
        flush = 1; iss_en = 1; iss_addr = 3'd4;
        wr1_en = 1; wr1_addr = 3'd7; wr1_data = 8'h77;
        tick(); idle_a();
        rd_addr = {3'd7, 3'd6};
        #1 chk("flush_vec", {24'h0, busy_vec_a}, 32'h00);
        chk("flush_write_commits", {24'h0, rd_data_a[15:8]}, 32'h77);
        chk("flush_rd_busy", {30'h0, rd_busy_a}, 32'h0);

        // mid-cycle reset with pending bit and live bypass
        iss_en = 1; iss_addr = 3'd1;
        tick(); idle_a();
        rd_addr = {3'd2, 3'd3};
        wr0_en = 1; wr0_addr = 3'd3; wr0_data = 8'hC3;
        #1 chk("pre_reset_vec", {24'h0, busy_vec_a}, 32'h02);
        #1 reset = 1;
        #1 chk("midreset_rd_data", {16'h0, rd_data_a}, 32'h0);
        chk("midreset_busy_vec", {24'h0, busy_vec_a}, 32'h0);
        chk("midreset_rd_data_b", {16'h0, rd_data_b}, 32'h0);
        chk("midreset_rd_busy", {30'h0, rd_busy_a}, 32'h0);
        tick();
        idle_a();
        reset = 0;
        #1 chk("post_reset_array", {16'h0, rd_data_a}, 32'h0);
        tick();

        // wide variant against the bench model
        for (int cyc = 0; cyc < 80; cyc++) begin
            c_wr0_en   = ($urandom_range(0, 2) == 0);
            c_wr0_addr = 4'($urandom_range(0, 15));
            c_wr0_data = 8'($urandom);
            c_wr1_en   = ($urandom_range(0, 1) == 0);
            c_wr1_addr = ($urandom_range(0, 3) == 0) ? c_wr0_addr : 4'($urandom_range(0, 15));
            c_wr1_data = 8'($urandom);
            c_iss_en   = ($urandom_range(0, 1) == 0);
            c_iss_addr = 4'($urandom_range(0, 15));
            c_flush    = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 4; p++) begin
                c_rd_addr[p*4 +: 4] = ($urandom_range(0, 3) == 0) ? c_wr1_addr : 4'($urandom_range(0, 15));
            end
            #1;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("w_data_p%0d", p), {24'h0, c_rd_data[p*8 +: 8]}, {24'h0, m_data(c_rd_addr[p*4 +: 4])});
                chk($sformatf("w_busy_p%0d", p), {31'h0, c_rd_busy[p]}, {31'h0, m_busy(c_rd_addr[p*4 +: 4])});
            end
            chk("w_busy_vec", {16'h0, c_busy_vec}, {16'h0, mpend});
            if (c_wr1_en && c_wr1_addr != 4'd0) mmem[c_wr1_addr] = c_wr1_data;
            if (c_wr0_en && c_wr0_addr != 4'd0) mmem[c_wr0_addr] = c_wr0_data;
            for (int r = 1; r < 16; r++) begin
                if (c_flush) mpend[r] = 1'b0;
                else if (c_iss_en && c_iss_addr == 4'(r)) mpend[r] = 1'b1;
                else if ((c_wr0_en && c_wr0_addr == 4'(r)) || (c_wr1_en && c_wr1_addr == 4'(r))) mpend[r] = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
